pe_vector_lane_array: RTL and testbench
=======================================

Name: pe_vector_lane_array

Overview:
- Multi-lane processing element: NUM_LANES independent signed lanes driven by one instruction stream.
- Each lane has a registered multiply stage and an accumulator register.
- Adds capabilities earlier lanes lack: valid/ready instruction handshake, per-lane write mask, optional saturating MAC/OUT, round-to-nearest shift, sticky per-lane overflow flags, and backpressured output.
- Sits between the operand fetch/sequencer and the output collector.

Parameters:
- NUM_LANES, 4, number of parallel lanes.
- INPUT_WIDTH, 8, signed operand width per lane.
- ACC_WIDTH, 16, signed accumulator width per lane.
- OUTPUT_WIDTH, 8, signed output width per lane.
- VALUE_BITWIDTH, 5, width of the instruction shift-value field.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  instruction accepted when valid&&ready.
- instr_op  in  3  0 NOP, 1 MAC, 2 RND, 3 PASS, 4 OUT, 5 CLR; 6-7 treated as NOP.
- instr_value  in  VALUE_BITWIDTH  unsigned shift amount for RND.
- instr_sat  in  1  saturate enable for MAC/OUT.
- instr_round  in  1  round-to-nearest enable for RND.
- lane_mask  in  NUM_LANES  bit i=1 lets lane i execute.
- vector_in  in  NUM_LANES*INPUT_WIDTH  packed signed operands, lane i at [i*INPUT_WIDTH +: INPUT_WIDTH].
- matrix_in  in  NUM_LANES*INPUT_WIDTH  packed signed operands, same packing.
- out_data  out  NUM_LANES*OUTPUT_WIDTH  packed registered lane outputs.
- out_valid  out  1  out_data holds an unconsumed OUT result.
- out_ready  in  1  consumer accepts out_data when out_valid&&out_ready.
- acc_overflow  out  NUM_LANES  sticky per-lane overflow flags.

Behaviour:
- Reset, asynchronous on rst_n low:
  - all accumulators, out_data, out_valid and acc_overflow go to 0;
  - the E1 stage is emptied.
- Pipeline:
  - Accept: instruction captured on the accepting edge into E1. Captured fields are op, value, sat, round, mask, and per-lane products vector_i*matrix_i, full 2*INPUT_WIDTH signed and sign-extended to ACC_WIDTH.
  - Commit: next edge while E1 is valid and not stalled, the instruction updates accumulators / out_data.
  - Latency: accept at edge t, architectural effect visible after edge t+1.
  - Throughput: one instruction per cycle.
  - No hazards: products never depend on acc, and acc is read and written only at commit.
- Stall:
  - stall = E1 valid && E1 op==OUT && out_valid && !out_ready.
  - instr_ready = !stall, combinational.
  - While stalled, E1 holds and nothing commits.
- Unmasked lanes: accumulator, out_data slice and overflow flag are unchanged for every op.
- Per-lane commit (masked lanes only):
  - MAC: s = acc + product, computed at ACC_WIDTH+1.
    - If s is outside ACC range, set acc_overflow[i].
    - sat=1: clamp to ACC max/min. sat=0: wrap to the low ACC_WIDTH bits.
  - RND, shift amount n = value:
    - round=0: acc >>> n; n >= ACC_WIDTH yields the sign fill.
    - round=1 and n>0: (acc + 2^(n-1)) >>> n, computed at ACC_WIDTH+1; the result always fits.
    - round=1 and n=0: unchanged.
  - PASS: acc = sign-extend(vector_i) taken from E1. E1 stores the vector operand alongside the product.
  - OUT: out_data lane = acc.
    - sat=1: clamp to OUTPUT range and set acc_overflow[i] if clamped.
    - sat=0: low OUTPUT_WIDTH bits.
  - CLR: acc=0, out_data lane=0, acc_overflow[i]=0.
  - NOP: nothing changes.
- out_valid:
  - Set on any OUT commit, even with an all-zero mask.
  - Cleared on out_valid&&out_ready with no OUT committing that edge.
  - OUT commit and consume on the same edge: out_valid stays 1 and data is replaced.
  - CLR does not change out_valid.
- acc_overflow: cleared only by reset or CLR.
- Reset mid-stall or mid-pipeline: E1 contents are discarded, with no partial commit.

Test Plan:
- Reset, then MAC mask=0001, lane0 vec=3 mat=-4 after PASS vec=10 -> lane0 acc=-2, commit one cycle after accept; lanes1-3 acc=0.
- acc=32767, MAC 1*1: sat=1 -> acc=32767, flag=1; sat=0 -> acc=-32768, flag=1; CLR -> flag=0.
- RND n=2 on acc=7 / acc=-6:
  - round=1 -> 2 / -1;
  - round=0 -> 1 / -2;
  - n=20 round=0 on -6 -> -1.
- acc=300, OUT: sat=1 -> out=127, flag=1; sat=0 -> out=44.
- out_ready=0, issue OUT, OUT, MAC back-to-back:
  - out_valid=1 after first commit;
  - instr_ready falls while the second OUT waits in E1;
  - raise out_ready -> second data replaces first, out_valid stays 1, MAC then commits.
- Assert rst_n low while an instruction is in E1 and while stalled -> all outputs 0 immediately, instr_ready=1 after release, no commit of the held instruction.

Source files
------------

// File: rtl/pe_vector_lane_array.sv
// Multi-lane signed MAC processing element: one instruction stream, per-lane accumulators,
// a single E1 stage between accept and commit, and a backpressured registered output.
module pe_vector_lane_array #(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned INPUT_WIDTH    = 8,
    parameter int unsigned ACC_WIDTH      = 16,
    parameter int unsigned OUTPUT_WIDTH   = 8,
    parameter int unsigned VALUE_BITWIDTH = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                instr_valid,
    output logic                                instr_ready,
    input  logic [2:0]                          instr_op,
    input  logic [VALUE_BITWIDTH-1:0]           instr_value,
    input  logic                                instr_sat,
    input  logic                                instr_round,
    input  logic [NUM_LANES-1:0]                lane_mask,
    input  logic [NUM_LANES*INPUT_WIDTH-1:0]    vector_in,
    input  logic [NUM_LANES*INPUT_WIDTH-1:0]    matrix_in,
    output logic [NUM_LANES*OUTPUT_WIDTH-1:0]   out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_LANES-1:0]                acc_overflow
);

    typedef enum logic [2:0] {
        OpNop  = 3'd0,
        OpMac  = 3'd1,
        OpRnd  = 3'd2,
        OpPass = 3'd3,
        OpOut  = 3'd4,
        OpClr  = 3'd5
    } op_e;

    localparam int OutMaxI = 2 ** (OUTPUT_WIDTH - 1) - 1;
    localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] OutMax = ACC_WIDTH'(OutMaxI);
    localparam logic signed [ACC_WIDTH-1:0] OutMin = ACC_WIDTH'(-OutMaxI - 1);

    // E1 stage
    logic                              e1_valid;
    op_e                               e1_op;
    logic [VALUE_BITWIDTH-1:0]         e1_value;
    logic                              e1_sat;
    logic                              e1_round;
    logic [NUM_LANES-1:0]              e1_mask;
    logic signed [ACC_WIDTH-1:0]       e1_prod [NUM_LANES];
    logic signed [INPUT_WIDTH-1:0]     e1_vec  [NUM_LANES];

    // Architectural state
    logic signed [ACC_WIDTH-1:0]       acc_q [NUM_LANES];
    logic signed [ACC_WIDTH-1:0]       acc_d [NUM_LANES];
    logic signed [OUTPUT_WIDTH-1:0]    out_q [NUM_LANES];
    logic signed [OUTPUT_WIDTH-1:0]    out_d [NUM_LANES];
    logic [NUM_LANES-1:0]              ovf_q;
    logic [NUM_LANES-1:0]              ovf_d;
    logic                              out_valid_d;

    logic signed [INPUT_WIDTH-1:0]     vec_in    [NUM_LANES];
    logic signed [INPUT_WIDTH-1:0]     mat_in    [NUM_LANES];
    logic signed [2*INPUT_WIDTH-1:0]   prod_full [NUM_LANES];
    logic signed [ACC_WIDTH-1:0]       prod_in   [NUM_LANES];

    logic stall;
    logic accept;
    logic commit;
    logic out_commit;

    assign stall       = e1_valid && (e1_op == OpOut) && out_valid && !out_ready;
    assign instr_ready = !stall;
    assign accept      = instr_valid && instr_ready;
    assign commit      = e1_valid && !stall;
    assign out_commit  = commit && (e1_op == OpOut);

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            vec_in[i]    = vector_in[i*INPUT_WIDTH +: INPUT_WIDTH];
            mat_in[i]    = matrix_in[i*INPUT_WIDTH +: INPUT_WIDTH];
            prod_full[i] = vec_in[i] * mat_in[i];
            prod_in[i]   = ACC_WIDTH'(prod_full[i]);
        end
    end

    // Per-lane commit; sums are formed one bit wider so overflow is just a top-bit mismatch.
    logic signed [ACC_WIDTH:0] mac_sum;
    logic signed [ACC_WIDTH:0] rnd_bias;
    logic signed [ACC_WIDTH:0] rnd_sum;

    always_comb begin
        mac_sum  = '0;
        rnd_bias = '0;
        rnd_sum  = '0;
        ovf_d    = ovf_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            acc_d[i] = acc_q[i];
            out_d[i] = out_q[i];
            mac_sum  = {acc_q[i][ACC_WIDTH-1], acc_q[i]} + {e1_prod[i][ACC_WIDTH-1], e1_prod[i]};
            rnd_bias = (ACC_WIDTH+1)'(1) << (e1_value - 1'b1);
            rnd_sum  = {acc_q[i][ACC_WIDTH-1], acc_q[i]} + rnd_bias;
            if (commit && e1_mask[i]) begin
                case (e1_op)
                    OpMac: begin
                        if (mac_sum[ACC_WIDTH] != mac_sum[ACC_WIDTH-1]) begin
                            ovf_d[i] = 1'b1;
                            if (e1_sat) acc_d[i] = mac_sum[ACC_WIDTH] ? AccMin : AccMax;
                            else        acc_d[i] = mac_sum[ACC_WIDTH-1:0];
                        end else begin
                            acc_d[i] = mac_sum[ACC_WIDTH-1:0];
                        end
                    end
                    OpRnd: begin
                        if (!e1_round) begin
                            if (32'(e1_value) >= ACC_WIDTH)
                                acc_d[i] = {ACC_WIDTH{acc_q[i][ACC_WIDTH-1]}};
                            else
                                acc_d[i] = acc_q[i] >>> e1_value;
                        end else if (e1_value != '0) begin
                            // Once n reaches the accumulator width the rounded result is zero.
                            if (32'(e1_value) >= ACC_WIDTH) acc_d[i] = '0;
                            else acc_d[i] = ACC_WIDTH'(rnd_sum >>> e1_value);
                        end
                    end
                    OpPass: acc_d[i] = ACC_WIDTH'(e1_vec[i]);
                    OpOut: begin
                        if (e1_sat && (acc_q[i] > OutMax)) begin
                            out_d[i] = OutMax[OUTPUT_WIDTH-1:0];
                            ovf_d[i] = 1'b1;
                        end else if (e1_sat && (acc_q[i] < OutMin)) begin
                            out_d[i] = OutMin[OUTPUT_WIDTH-1:0];
                            ovf_d[i] = 1'b1;
                        end else begin
                            out_d[i] = acc_q[i][OUTPUT_WIDTH-1:0];
                        end
                    end
                    OpClr: begin
                        acc_d[i] = '0;
                        out_d[i] = '0;
                        ovf_d[i] = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // An OUT commit wins over a same-edge consume so fresh data is never dropped.
    always_comb begin
        out_valid_d = out_valid;
        if (out_commit)                   out_valid_d = 1'b1;
        else if (out_valid && out_ready)  out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_valid  <= 1'b0;
            e1_op     <= OpNop;
            e1_value  <= '0;
            e1_sat    <= 1'b0;
            e1_round  <= 1'b0;
            e1_mask   <= '0;
            ovf_q     <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                e1_prod[i] <= '0;
                e1_vec[i]  <= '0;
                acc_q[i]   <= '0;
                out_q[i]   <= '0;
            end
        end else begin
            if (!stall) begin
                e1_valid <= accept;
                if (accept) begin
                    e1_op    <= op_e'(instr_op);
                    e1_value <= instr_value;
                    e1_sat   <= instr_sat;
                    e1_round <= instr_round;
                    e1_mask  <= lane_mask;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        e1_prod[i] <= prod_in[i];
                        e1_vec[i]  <= vec_in[i];
                    end
                end
            end
            ovf_q     <= ovf_d;
            out_valid <= out_valid_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                acc_q[i] <= acc_d[i];
                out_q[i] <= out_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_out
        assign out_data[g*OUTPUT_WIDTH +: OUTPUT_WIDTH] = out_q[g];
    end

    assign acc_overflow = ovf_q;

endmodule

// File: tb/tb_pe_vector_lane_array.sv
// Directed bench for pe_vector_lane_array: accumulators checked against hand-derived constants,
// OUT results tracked through a scoreboard queue and compared when the DUT presents them.
module tb_pe_vector_lane_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [4:0]  instr_value;
    logic        instr_sat;
    logic        instr_round;
    logic [3:0]  lane_mask;
    logic [31:0] vector_in;
    logic [31:0] matrix_in;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  acc_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb [$];

    localparam logic [2:0] NOP = 3'd0, MAC = 3'd1, RND = 3'd2, PASS = 3'd3, OUT = 3'd4,
                           CLR = 3'd5;

    pe_vector_lane_array dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_value  (instr_value),
        .instr_sat    (instr_sat),
        .instr_round  (instr_round),
        .lane_mask    (lane_mask),
        .vector_in    (vector_in),
        .matrix_in    (matrix_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .acc_overflow (acc_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] accs();
        return {dut.acc_q[3], dut.acc_q[2], dut.acc_q[1], dut.acc_q[0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the instruction until an accepting edge, then returns 1 time unit after it.
    task automatic issue(input logic [2:0] op, input logic [4:0] val, input logic sat,
                         input logic rnd, input logic [3:0] mask, input logic [31:0] vec,
                         input logic [31:0] mat);
        logic ok;
        logic done;
        instr_op    = op;
        instr_value = val;
        instr_sat   = sat;
        instr_round = rnd;
        lane_mask   = mask;
        vector_in   = vec;
        matrix_in   = mat;
        instr_valid = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            ok = instr_ready;
            @(posedge clk);
            if (ok) done = 1'b1;
        end
        chk("issue_accept_timeout", {63'd0, done}, 64'd1);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic check_out(input string tag);
        logic [31:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
            chk(tag, {32'd0, out_data}, {32'd0, e});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr_op = NOP;
        instr_value = '0;
        instr_sat = 1'b0;
        instr_round = 1'b0;
        lane_mask = '0;
        vector_in = '0;
        matrix_in = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_overflow", {60'd0, acc_overflow}, 64'd0);
        chk("rst_instr_ready", {63'd0, instr_ready}, 64'd1);
        chk("rst_acc", accs(), 64'd0);
        rst_n = 1'b1;
        step();

        // PASS then MAC on lane 0 only; other lanes see nonzero operands but stay masked
        issue(PASS, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h0505050a, 32'h07070707);
        chk("pass_not_yet", accs(), 64'd0);
        step();
        chk("pass_commit", accs(), 64'h0000_0000_0000_000a);
        issue(MAC, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h05050503, 32'h070707fc);
        chk("mac_not_yet", accs(), 64'h0000_0000_0000_000a);
        step();
        chk("mac_commit", accs(), 64'h0000_0000_0000_fffe);

        // Overflow: build 32767 = 16384 + 16129 + 254
        issue(CLR, 5'd0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        issue(MAC, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h00000080, 32'h00000080);
        issue(MAC, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h0000007f, 32'h0000007f);
        issue(MAC, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h0000007f, 32'h00000002);
        step();
        chk("acc_max_build", accs(), 64'h0000_0000_0000_7fff);
        chk("no_ovf_yet", {60'd0, acc_overflow}, 64'd0);
        issue(MAC, 5'd0, 1'b1, 1'b0, 4'b0001, 32'h00000001, 32'h00000001);
        step();
        chk("mac_sat_acc", accs(), 64'h0000_0000_0000_7fff);
        chk("mac_sat_ovf", {60'd0, acc_overflow}, 64'd1);
        issue(MAC, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h00000001, 32'h00000001);
        step();
        chk("mac_wrap_acc", accs(), 64'h0000_0000_0000_8000);
        chk("mac_wrap_ovf", {60'd0, acc_overflow}, 64'd1);
        issue(CLR, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h0, 32'h0);
        step();
        chk("clr_acc", accs(), 64'd0);
        chk("clr_ovf", {60'd0, acc_overflow}, 64'd0);

        // RND on lane0=7, lane1=-6
        issue(PASS, 5'd0, 1'b0, 1'b0, 4'b0011, 32'h0000fa07, 32'h0);
        issue(RND, 5'd2, 1'b0, 1'b1, 4'b0011, 32'h0, 32'h0);
        step();
        chk("rnd_round", accs(), 64'h0000_0000_ffff_0002);
        issue(PASS, 5'd0, 1'b0, 1'b0, 4'b0011, 32'h0000fa07, 32'h0);
        issue(RND, 5'd2, 1'b0, 1'b0, 4'b0011, 32'h0, 32'h0);
        step();
        chk("rnd_trunc", accs(), 64'h0000_0000_fffe_0001);
        issue(PASS, 5'd0, 1'b0, 1'b0, 4'b0011, 32'h0000fa07, 32'h0);
        issue(RND, 5'd20, 1'b0, 1'b0, 4'b0010, 32'h0, 32'h0);
        step();
        chk("rnd_big_shift", accs(), 64'h0000_0000_ffff_0007);

        // OUT with acc=300
        issue(CLR, 5'd0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        issue(PASS, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h00000064, 32'h0);
        issue(MAC, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h0000000a, 32'h00000014);
        step();
        chk("acc_300", accs(), 64'h0000_0000_0000_012c);
        issue(OUT, 5'd0, 1'b1, 1'b0, 4'b0001, 32'h0, 32'h0);
        sb.push_back(32'h0000007f);
        step();
        check_out("out_sat");
        chk("out_sat_ovf", {60'd0, acc_overflow}, 64'd1);
        issue(OUT, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h0, 32'h0);
        sb.push_back(32'h0000002c);
        step();
        check_out("out_wrap");
        step();
        chk("out_consumed", {63'd0, out_valid}, 64'd0);

        // Backpressure: OUT, OUT, MAC with consumer stalled
        issue(PASS, 5'd0, 1'b0, 1'b0, 4'b0011, 32'h0000fd05, 32'h0);
        step();
        out_ready = 1'b0;
        issue(OUT, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h0, 32'h0);
        sb.push_back(32'h00000005);
        issue(OUT, 5'd0, 1'b0, 1'b0, 4'b0011, 32'h0, 32'h0);
        sb.push_back(32'h0000fd05);
        check_out("stall_first");
        instr_op = MAC; lane_mask = 4'b0001; instr_sat = 1'b0;
        vector_in = 32'h00000003; matrix_in = 32'h00000004; instr_valid = 1'b1;
        step();
        chk("stall_ready_low", {63'd0, instr_ready}, 64'd0);
        chk("stall_data_hold", {32'd0, out_data}, 64'h0000_0005);
        step();
        chk("stall_ready_low2", {63'd0, instr_ready}, 64'd0);
        chk("stall_acc_hold", accs(), 64'h0000_0000_fffd_0005);
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", {63'd0, instr_ready}, 64'd1);
        step();
        instr_valid = 1'b0;
        check_out("stall_second");
        chk("stall_mac_pending", accs(), 64'h0000_0000_fffd_0005);
        step();
        chk("stall_mac_commit", accs(), 64'h0000_0000_fffd_0011);
        chk("stall_valid_clear", {63'd0, out_valid}, 64'd0);

        // Reset with an instruction sitting in E1
        issue(PASS, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h00000055, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_acc", accs(), 64'd0);
        chk("midrst_ovf", {60'd0, acc_overflow}, 64'd0);
        chk("midrst_data", {32'd0, out_data}, 64'd0);
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        #2;
        rst_n = 1'b1;
        chk("midrst_ready", {63'd0, instr_ready}, 64'd1);
        step();
        step();
        chk("midrst_no_commit", accs(), 64'd0);

        // Reset while stalled
        out_ready = 1'b0;
        issue(PASS, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h00000003, 32'h0);
        issue(OUT, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h0, 32'h0);
        sb.push_back(32'h00000003);
        issue(OUT, 5'd0, 1'b0, 1'b0, 4'b0001, 32'h0, 32'h0);
        sb.push_back(32'h00000003);
        check_out("strst_first");
        step();
        chk("strst_stalled", {63'd0, instr_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("strst_valid", {63'd0, out_valid}, 64'd0);
        chk("strst_data", {32'd0, out_data}, 64'd0);
        chk("strst_acc", accs(), 64'd0);
        #2;
        rst_n = 1'b1;
        chk("strst_ready", {63'd0, instr_ready}, 64'd1);
        out_ready = 1'b1;
        step();
        step();
        chk("strst_no_commit", {63'd0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
